// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - shared types and constants for the instruction fetch queue
package ifq_pkg;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam int PC_STEP     = 4;
  localparam int IFQ_ADDR_W  = 8;
  localparam int IFQ_INSTR_W = 32;

  typedef struct packed {
    logic [IFQ_ADDR_W-1:0]  pc;
    logic [IFQ_INSTR_W-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - synchronous DEPTH-entry FIFO with flush, count and head data
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter  int W     = 40,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // entry storage; contents are only observed through count-gated head reads
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // pointers and occupancy; flush empties the queue in one cycle
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - sequential PC fetch with credit-limited ROM requests and an output queue; optional IFQ_BYPASS_EN
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = ADDR_W + INSTR_W;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   fetch_pc;
  logic                inflight;
  logic                infl_epoch;
  logic                epoch;
  logic [ADDR_W-1:0]   infl_addr;
  logic [CW-1:0]       count;
  logic [CW:0]         credit_used;
  logic                empty;
  logic [W-1:0]        head;
  logic                resp_ok;
  logic                push;
  logic                pop;

  // a response is usable only if it belongs to the current epoch and no redirect is flushing this cycle
  assign resp_ok     = inflight && (infl_epoch == epoch) && !redirect;
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign mem_addr    = fetch_pc;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next state and request issue; queue slots plus the in-flight response bound outstanding work
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    if (redirect) state_d = S_RUN;
    if ((state_q == S_RUN) && !redirect && (credit_used < (CW+1)'(DEPTH))) begin
      mem_req = 1'b1;
    end
  end

  // fetch PC, in-flight tracking and the epoch that marks older responses stale
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc   <= '0;
      inflight   <= 1'b0;
      infl_epoch <= 1'b0;
      infl_addr  <= '0;
      epoch      <= 1'b0;
    end else begin
      inflight   <= mem_req;
      infl_epoch <= epoch;
      if (mem_req) infl_addr <= fetch_pc;
      if (redirect) begin
        fetch_pc <= redirect_pc & ~ADDR_W'(3);
        epoch    <= ~epoch;
      end else if (mem_req) begin
        fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      end
    end
  end

  // output selection, queue push and pop; redirect hides the head and blocks any transfer
  always_comb begin
    out_valid = 1'b0;
    out_instr = '0;
    out_pc    = '0;
    push      = 1'b0;
    pop       = 1'b0;
`ifdef IFQ_BYPASS_EN
    if (!empty) begin
      out_valid = !redirect;
      out_pc    = head[W-1:INSTR_W];
      out_instr = head[INSTR_W-1:0];
      push      = resp_ok;
    end else if (resp_ok) begin
      out_valid = 1'b1;
      out_pc    = infl_addr;
      out_instr = mem_rdata;
      push      = !out_ready;
    end
`else
    if (!empty) begin
      out_valid = !redirect;
      out_pc    = head[W-1:INSTR_W];
      out_instr = head[INSTR_W-1:0];
    end
    push = resp_ok;
`endif
    pop = out_valid && out_ready && !empty;
  end

  ifq_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push),
    .push_data ({infl_addr, mem_rdata}),
    .pop       (pop),
    .count     (count),
    .empty     (empty),
    .head      (head)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed self-checking bench for ifetch_queue
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;

  int checks = 0;
  int errors = 0;

  ifetch_queue #(.ADDR_W(8), .INSTR_W(32), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [7:0] a);
    return {8'h5A, a, ~a, a ^ 8'h3C};
  endfunction

  // synchronous ROM: data one cycle after the strobe, junk otherwise
  always @(posedge clk) begin
    if (mem_req) mem_rdata <= rom(mem_addr);
    else         mem_rdata <= 32'hDEADBEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [7:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    #1;
    chk("redir_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_req", {31'd0, mem_req}, 32'd0);
    tick();
    redirect = 1'b0;
  endtask

  task automatic run_stream(input logic [7:0] base, input int n);
    logic [7:0] a;
    logic [7:0] p;
    for (int k = 0; k < n; k++) begin
      #1;
      a = base + 8'(4 * k);
      chk("str_req", {31'd0, mem_req}, 32'd1);
      chk("str_addr", {24'd0, mem_addr}, {24'd0, a});
      if (k >= LAT) begin
        p = base + 8'(4 * (k - LAT));
        chk("str_valid", {31'd0, out_valid}, 32'd1);
        chk("str_pc", {24'd0, out_pc}, {24'd0, p});
        chk("str_instr", out_instr, rom(p));
      end else begin
        chk("str_novalid", {31'd0, out_valid}, 32'd0);
      end
      tick();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    out_ready   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", {24'd0, out_pc}, 32'd0);
    tick();
    chk("idle_req", {31'd0, mem_req}, 32'd0);

    // basic stream from 0x10
    out_ready = 1'b1;
    redirect_to(8'h10);
    run_stream(8'h10, 6);

    // stalled decode: queue fills with four entries and requests stop
    out_ready = 1'b0;
    redirect_to(8'h00);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("stall_req", {31'd0, mem_req}, (k < 4) ? 32'd1 : 32'd0);
      if (k < 4) chk("stall_addr", {24'd0, mem_addr}, 32'(4 * k));
      if (k >= LAT) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_pc", {24'd0, out_pc}, 32'd0);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("resume_req0", {31'd0, mem_req}, 32'd0);
    chk("resume_pc0", {24'd0, out_pc}, 32'd0);
    tick();
    #1;
    chk("resume_req1", {31'd0, mem_req}, 32'd1);
    chk("resume_addr1", {24'd0, mem_addr}, 32'h10);
    chk("resume_pc1", {24'd0, out_pc}, 32'h04);
    tick();

    // address wrap through 0xFC
    redirect_to(8'hF8);
    run_stream(8'hF8, 6);

    // redirect with two queued entries and one response in flight
    out_ready = 1'b0;
    redirect_to(8'h80);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("pre_req", {31'd0, mem_req}, 32'd1);
      tick();
    end
    #1;
    chk("pre_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_pc", {24'd0, out_pc}, 32'h80);
    redirect_to(8'h40);
    out_ready = 1'b1;
    run_stream(8'h40, 6);

    // unaligned redirect target
    redirect_to(8'h23);
    run_stream(8'h20, 4);

    // reset mid-stream
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("mrst_req", {31'd0, mem_req}, 32'd0);
    chk("mrst_addr", {24'd0, mem_addr}, 32'd0);
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_instr", out_instr, 32'd0);
    chk("mrst_pc", {24'd0, out_pc}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("mrst_idle_req", {31'd0, mem_req}, 32'd0);
      chk("mrst_idle_valid", {31'd0, out_valid}, 32'd0);
    end
    tick();
    redirect_to(8'h08);
    run_stream(8'h08, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Consumer end of the program-counter address interface for the single-cycle MIPS.
- Takes a start PC on redirect, issues sequential word addresses to a synchronous instruction ROM, and buffers the returned instructions with their PCs in a small FIFO.
- Hands instructions to decode over a valid/ready handshake. Decouples the fetch rate from decode stalls.

Parameters:
- ADDR_W, 8, PC and instruction-memory byte-address width.
- INSTR_W, 32, instruction word width.
- DEPTH, 4, queue entries (power of 2, at least 2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- redirect  in  1  load a new fetch PC and flush the queue.
- redirect_pc  in  ADDR_W  new fetch PC; bits [1:0] are ignored and treated as 0.
- mem_req  out  1  instruction-ROM read strobe.
- mem_addr  out  ADDR_W  ROM byte address; word aligned.
- mem_rdata  in  INSTR_W  ROM data, valid exactly 1 cycle after mem_req.
- out_valid  out  1  an instruction is available to decode.
- out_ready  in  1  decode accepts the instruction.
- out_instr  out  INSTR_W  head instruction.
- out_pc  out  ADDR_W  PC of the head instruction.

Behaviour:
- Reset (rst_n=0 at a posedge):
  - state=S_IDLE, fetch_pc=0, queue empty, in-flight flag=0.
  - mem_req=0, mem_addr=0, out_valid=0, out_instr=0, out_pc=0.
  - Reset mid-operation drops any pending ROM response.
- FSM:
  - S_IDLE: no requests issued. redirect moves to S_RUN.
  - S_RUN: fetching. redirect stays in S_RUN with a new fetch_pc.
  - There is no return to S_IDLE except by reset.
- Issue rule in S_RUN:
  - mem_req=1 when (count + inflight) < DEPTH and redirect=0.
  - mem_addr=fetch_pc.
  - On issue, fetch_pc <= fetch_pc + 4, modulo 2^ADDR_W (8'hFC wraps to 8'h00).
- Response:
  - The cycle after an issue, mem_rdata and the issued address are pushed into the queue at that cycle's edge.
  - Default latency: req at cycle t, out_valid at t+2.
- Credit accounting guarantees no overflow; a push never arrives when the queue is full.
- Pop: occurs when out_valid & out_ready. A push and a pop in the same cycle leave count unchanged.
- out_valid equals queue not empty. out_instr and out_pc show the head entry and hold stable while out_valid=1 and out_ready=0.
- Redirect cycle:
  - out_valid is forced to 0 combinationally; no transfer occurs.
  - Queue is flushed and count=0.
  - The in-flight response is tagged stale by an epoch bit and discarded the next cycle.
  - fetch_pc <= {redirect_pc[7:2], 2'b00}.
  - The first new request is issued the cycle after redirect.
- Redirect has priority over issue, push and pop in the same cycle. Reset has priority over everything.
- Back-to-back redirects: only the last one takes effect; each discards prior responses.
- Throughput: with out_ready held at 1, one instruction per cycle in steady state.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined:
  - When the queue is empty and a valid (non-stale) response arrives, out_valid=1 in the same cycle, with out_instr=mem_rdata and out_pc equal to the in-flight address.
  - If out_ready=1 that cycle, the entry is not written to the queue.
  - Minimum latency becomes req at t, out_valid at t+1.
  - Bypass is also suppressed on a redirect cycle.
- Undefined: the response path is always registered through the queue, with latency t+2. No combinational path from mem_rdata to the outputs.

Decomposition:
- Package ifq_pkg holds:
  - state enum {S_IDLE, S_RUN};
  - constant PC_STEP=4;
  - the entry struct {pc, instr}.
- One natural sub-module, ifq_fifo: a synchronous DEPTH-entry FIFO with push, pop, flush, count, head data and a registered pointer array.
- ifetch_queue keeps the FSM, credit logic, epoch tag and bypass.

Test Plan:
- Reset, then redirect to 8'h10 with out_ready=1 -> mem_addr 10,14,18,1C on consecutive cycles; out_pc 10,14,18,1C starting 2 cycles after the first request (1 cycle with IFQ_BYPASS_EN).
- out_ready=0 after redirect to 8'h00 -> exactly 4 requests (00,04,08,0C), then mem_req=0; out_pc holds 00. Raising out_ready resumes issue the next cycle.
- Redirect to 8'hF8 -> addresses F8, FC, 00, 04; out_pc follows the same wrap.
- Redirect to 8'h40 while one response is in flight and the queue holds 2 entries -> out_valid=0 that cycle; stale data never appears; next out_pc=40.
- Redirect to 8'h23 -> fetch starts at 8'h20.
- rst_n=0 for 1 cycle mid-stream -> all outputs 0 next cycle; no requests until a new redirect.
